multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu_pkg.sv | 35 +++
 rtl/alu_comb.sv | 58 +++++
 rtl/multicycle_alu.sv | 119 +++++++++++
 tb/tb_multicycle_alu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared opcode bit positions, opcode masks and FSM state codes for the multicycle ALU.
`default_nettype none

package multicycle_alu_pkg;

    localparam int OP_MUL = 0;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_INC = 3;
    localparam int OP_DEC = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_NOT = 7;

    localparam logic [7:0] OPM_MUL = 8'h01;
    localparam logic [7:0] OPM_ADD = 8'h02;
    localparam logic [7:0] OPM_SUB = 8'h04;
    localparam logic [7:0] OPM_INC = 8'h08;
    localparam logic [7:0] OPM_DEC = 8'h10;
    localparam logic [7:0] OPM_AND = 8'h20;
    localparam logic [7:0] OPM_OR  = 8'h40;
    localparam logic [7:0] OPM_NOT = 8'h80;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// Combinational datapath for the single-cycle ALU operations and their status flag.
`default_nettype none

module alu_comb
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NOPS  = 8
) (
    input  logic [NOPS-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             err
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] sub_sum;

    assign add_sum = {1'b0, a} + {1'b0, b};
    // Two's-complement subtract; the carry out is the inverse of the borrow.
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        flag   = 1'b0;
        err    = !is_onehot(op);
        case (op)
            OPM_ADD: begin
                result = add_sum[WIDTH-1:0];
                flag   = add_sum[WIDTH];
            end
            OPM_SUB: begin
                result = sub_sum[WIDTH-1:0];
                flag   = !sub_sum[WIDTH];
            end
            OPM_INC: begin
                result = a + {{(WIDTH-1){1'b0}}, 1'b1};
                flag   = &a;
            end
            OPM_DEC: begin
                result = a - {{(WIDTH-1){1'b0}}, 1'b1};
                flag   = (a == '0);
            end
            OPM_AND: result = a & b;
            OPM_OR:  result = a | b;
            OPM_NOT: result = ~a;
            default: begin
                result = '0;
                flag   = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus a WIDTH-cycle shift-add multiplier.
`default_nettype none

module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NOPS  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NOPS-1:0]  op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             flag,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_hi;

    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;
    logic             alu_err;
    logic             accept;
    logic             is_mul;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    alu_comb #(
        .WIDTH (WIDTH),
        .NOPS  (NOPS)
    ) u_alu_comb (
        .op     (op),
        .a      (data1),
        .b      (data2),
        .result (alu_res),
        .flag   (alu_flag),
        .err    (alu_err)
    );

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OPM_MUL);

    // One shift-add step: the low half of the product shifts in through mplier.
    assign step_sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign hi_next  = step_sum[WIDTH:1];
    assign lo_next  = {step_sum[0], mplier[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            out    <= '0;
            out_hi <= '0;
            flag   <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state  <= ST_BUSY;
                            mcand  <= data1;
                            mplier <= data2;
                            acc_hi <= '0;
                            count  <= CW'(WIDTH);
                        end else begin
                            state  <= ST_DONE;
                            out    <= alu_res;
                            out_hi <= '0;
                            flag   <= alu_flag;
                            zero   <= (alu_res == '0);
                            err    <= alu_err;
                        end
                    end else if (state == ST_DONE && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_hi <= hi_next;
                    mplier <= lo_next;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state  <= ST_DONE;
                        out    <= lo_next;
                        out_hi <= hi_next;
                        flag   <= |hi_next;
                        zero   <= ~|{hi_next, lo_next};
                        err    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=8: results queued at accept, compared at handshake.
`default_nettype none

module tb_multicycle_alu;

    localparam int W = 8;

    typedef struct {
        logic [7:0] out;
        logic [7:0] hi;
        logic       flag;
        logic       zero;
        logic       err;
        int         first_cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] out_hi;
    logic       flag;
    logic       zero;
    logic       err;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    multicycle_alu #(.WIDTH(W), .NOPS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .flag      (flag),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        longint unsigned s;
        e.out = 8'h00; e.hi = 8'h00; e.flag = 1'b0; e.err = 1'b0; e.first_cyc = 0;
        case (o)
            8'h01: begin
                s = longint'(a) * longint'(b);
                e.out = s[7:0]; e.hi = s[15:8]; e.flag = (s[15:8] != 8'h00);
            end
            8'h02: begin
                s = longint'(a) + longint'(b);
                e.out = s[7:0]; e.flag = (s > 255);
            end
            8'h04: begin e.out = a - b;     e.flag = (a < b);      end
            8'h08: begin e.out = a + 8'd1;  e.flag = (a == 8'hFF); end
            8'h10: begin e.out = a - 8'd1;  e.flag = (a == 8'h00); end
            8'h20: e.out = a & b;
            8'h40: e.out = a | b;
            8'h80: e.out = ~a;
            default: e.err = 1'b1;
        endcase
        e.zero = (e.out == 8'h00) && (e.hi == 8'h00);
        return e;
    endfunction

    // Presents one operation, waits for acceptance, and queues the expected result.
    task automatic issue(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   w = 0;
        in_valid = 1'b1; op = o; data1 = a; data2 = b;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        e = model(o, a, b);
        e.first_cyc = cyc + ((o == 8'h01) ? W : 0);
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    // Output monitor: latency on the first cycle of each result, data at the handshake.
    initial begin : monitor
        exp_t e;
        bit   fresh = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fresh = 1'b1;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    if (fresh) check("unexpected_valid", 1, 0);
                    fresh = out_ready;
                end else begin
                    if (fresh) begin
                        check("latency", cyc, sb[0].first_cyc);
                        fresh = 1'b0;
                    end
                    if (out_ready) begin
                        e = sb.pop_front();
                        check("out", out, e.out);
                        check("out_hi", out_hi, e.hi);
                        check("flag", flag, e.flag);
                        check("zero", zero, e.zero);
                        check("err", err, e.err);
                        fresh = 1'b1;
                    end
                end
            end else begin
                fresh = 1'b1;
            end
        end
    end

    initial begin : main
        int busy;
        int seen;
        int w;
        logic [7:0] ro;
        rst_n = 1'b1; in_valid = 1'b0; op = 8'h00; data1 = 8'h00; data2 = 8'h00; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_out_hi", out_hi, 0);
        check("rst_flag_zero_err", {flag, zero, err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Carry out of ADD, then a single-cycle valid pulse.
        issue(8'h02, 8'hF0, 8'h20);
        @(negedge clk);
        @(negedge clk);
        check("add_valid_pulse", out_valid, 0);

        // Borrow on SUB followed immediately by DEC of zero.
        @(posedge clk); #1;
        issue(8'h04, 8'h05, 8'h06);
        issue(8'h10, 8'h00, 8'h33);

        // MUL with ignored junk inputs while busy.
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue(8'h01, 8'hFF, 8'hFF);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; op = 8'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
            @(negedge clk);
            if (in_ready) break;
            busy++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mul_busy_cycles", busy, W);

        // Backpressure: result must hold while out_ready is low.
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(8'h02, 8'h33, 8'h44);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out", {out_valid, in_ready, out, out_hi, flag, zero, err},
                  {1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_release_idle", out_valid, 0);

        // Non-one-hot opcodes.
        @(posedge clk); #1;
        issue(8'h03, 8'h12, 8'h34);
        issue(8'h00, 8'hAB, 8'hCD);

        // Mixed one-hot operations, MUL included.
        for (int i = 0; i < 24; i++) begin
            ro = 8'h01 << $urandom_range(0, 7);
            issue(ro, 8'($urandom), 8'($urandom));
        end
        issue(8'h08, 8'hFF, 8'h00);
        issue(8'h01, 8'h00, 8'h5A);

        // Reset three cycles into a MUL abandons it.
        issue(8'h02, 8'h01, 8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue(8'h01, 8'h12, 8'h34);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        check("mrst_outs", {out_valid, out, out_hi, flag, zero, err}, 0);
        check("mrst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mrst_no_result", seen, 0);
        @(posedge clk); #1;
        issue(8'h20, 8'h3C, 8'h0F);

        w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("drain", sb.size(), 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
